// File: rtl/id_ex_if.sv
// ID/EX stage bundle: ID instruction, register-file read port, writeback bypass source,
// pipeline control and the registered EX-side fields.
interface id_ex_if #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 16
);
  logic          id_valid;
  logic [31:0]   id_instr;
  logic [DW-1:0] id_pc4;
  logic [AW-1:0] rf_a1;
  logic [AW-1:0] rf_a2;
  logic [DW-1:0] rf_rd1;
  logic [DW-1:0] rf_rd2;
  logic          wb_we;
  logic [AW-1:0] wb_a3;
  logic [DW-1:0] wb_wd;
  logic          flush;
  logic          ex_stall;
  logic          stall_id;
  logic          ex_valid;
  logic [5:0]    ex_op;
  logic [5:0]    ex_funct;
  logic [AW-1:0] ex_rs;
  logic [AW-1:0] ex_rt;
  logic [AW-1:0] ex_rd;
  logic [DW-1:0] ex_imm;
  logic [DW-1:0] ex_a;
  logic [DW-1:0] ex_b;
  logic [DW-1:0] ex_pc4;
  logic [CW-1:0] bubble_cnt;

  modport master (
    output id_valid, id_instr, id_pc4, rf_rd1, rf_rd2, wb_we, wb_a3, wb_wd, flush, ex_stall,
    input  rf_a1, rf_a2, stall_id, ex_valid, ex_op, ex_funct, ex_rs, ex_rt, ex_rd,
           ex_imm, ex_a, ex_b, ex_pc4, bubble_cnt
  );

  modport slave (
    input  id_valid, id_instr, id_pc4, rf_rd1, rf_rd2, wb_we, wb_a3, wb_wd, flush, ex_stall,
    output rf_a1, rf_a2, stall_id, ex_valid, ex_op, ex_funct, ex_rs, ex_rt, ex_rd,
           ex_imm, ex_a, ex_b, ex_pc4, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with same-cycle writeback bypass, load-use
// hazard detection, flush/stall handling and a saturating hazard-bubble counter.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 16
) (
  input  logic  clk,
  input  logic  rst,
  id_ex_if.slave bus
);
  localparam logic [5:0]    OP_RTYPE = 6'h00;
  localparam logic [5:0]    OP_BEQ   = 6'h04;
  localparam logic [5:0]    OP_BNE   = 6'h05;
  localparam logic [5:0]    OP_LW    = 6'h23;
  localparam logic [5:0]    OP_SW    = 6'h2B;
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef struct packed {
    logic          valid;
    logic [5:0]    op;
    logic [5:0]    funct;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic [DW-1:0] imm;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] pc4;
  } ex_slot_t;

  ex_slot_t      ex_q;
  ex_slot_t      ex_d;
  logic [CW-1:0] bubble_cnt_q;
  logic [CW-1:0] bubble_cnt_d;

  logic [5:0]    id_op_s;
  logic [AW-1:0] id_rs_s;
  logic [AW-1:0] id_rt_s;
  logic [AW-1:0] id_rd_s;
  logic [DW-1:0] id_imm_s;
  logic [DW-1:0] op_a_s;
  logic [DW-1:0] op_b_s;
  logic          uses_rt_s;
  logic          haz_s;
  logic          load_bubble_s;
  logic          capture_s;

  assign id_op_s  = bus.id_instr[31:26];
  assign id_rs_s  = bus.id_instr[21 +: AW];
  assign id_rt_s  = bus.id_instr[16 +: AW];
  assign id_rd_s  = bus.id_instr[11 +: AW];
  assign id_imm_s = {{(DW-16){bus.id_instr[15]}}, bus.id_instr[15:0]};

  assign bus.rf_a1 = id_rs_s;
  assign bus.rf_a2 = id_rt_s;

  // r0 is an ordinary register in this file, so the bypass compares address 0 too
  assign op_a_s = (bus.wb_we && (bus.wb_a3 == id_rs_s)) ? bus.wb_wd : bus.rf_rd1;
  assign op_b_s = (bus.wb_we && (bus.wb_a3 == id_rt_s)) ? bus.wb_wd : bus.rf_rd2;

  // Opcodes whose rt field is a source operand
  always_comb begin
    case (id_op_s)
      OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: uses_rt_s = 1'b1;
      default:                         uses_rt_s = 1'b0;
    endcase
  end

  assign haz_s = bus.id_valid && ex_q.valid && (ex_q.op == OP_LW) &&
                 ((ex_q.rt == id_rs_s) || (uses_rt_s && (ex_q.rt == id_rt_s)));

  assign bus.stall_id  = (haz_s || bus.ex_stall) && !bus.flush;
  assign load_bubble_s = bus.flush || (!bus.ex_stall && haz_s);
  assign capture_s     = !bus.flush && !bus.ex_stall && !haz_s;

  // EX slot next state: flush beats stall beats hazard beats normal capture
  always_comb begin
    ex_d = ex_q;
    if (load_bubble_s) begin
      ex_d = '0;
    end else if (capture_s) begin
      ex_d.valid = bus.id_valid;
      ex_d.op    = id_op_s;
      ex_d.funct = bus.id_instr[5:0];
      ex_d.rs    = id_rs_s;
      ex_d.rt    = id_rt_s;
      ex_d.rd    = id_rd_s;
      ex_d.imm   = id_imm_s;
      ex_d.a     = op_a_s;
      ex_d.b     = op_b_s;
      ex_d.pc4   = bus.id_pc4;
    end else begin
      ex_d = ex_q;
    end
  end

  // Only hazard bubbles that are actually inserted are counted
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (!bus.flush && !bus.ex_stall && haz_s && (bubble_cnt_q != CNT_MAX)) begin
      bubble_cnt_d = bubble_cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      bubble_cnt_d = bubble_cnt_q;
    end
  end

  // EX pipeline register and bubble counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q         <= '0;
      bubble_cnt_q <= {CW{1'b0}};
    end else begin
      ex_q         <= ex_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.ex_valid   = ex_q.valid;
  assign bus.ex_op      = ex_q.op;
  assign bus.ex_funct   = ex_q.funct;
  assign bus.ex_rs      = ex_q.rs;
  assign bus.ex_rt      = ex_q.rt;
  assign bus.ex_rd      = ex_q.rd;
  assign bus.ex_imm     = ex_q.imm;
  assign bus.ex_a       = ex_q.a;
  assign bus.ex_b       = ex_q.b;
  assign bus.ex_pc4     = ex_q.pc4;
  assign bus.bubble_cnt = bubble_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against an instruction-level model
// of the EX slot (whole instruction word plus operands) and the hazard counter.
module tb_id_ex_stage;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_if #(.DW(32), .AW(5), .CW(CW)) bus ();

  id_ex_stage #(.DW(32), .AW(5), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic [31:0] m_pc4;
  int          m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic model_clear_slot();
    m_valid = 1'b0;
    m_instr = 32'h0;
    m_a     = 32'h0;
    m_b     = 32'h0;
    m_pc4   = 32'h0;
  endtask

  // Load in EX whose destination is read by the ID instruction
  function automatic logic model_haz();
    logic [5:0] op;
    logic       reads_rt;
    op       = bus.id_instr[31:26];
    reads_rt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
    return bus.id_valid && m_valid && (m_instr[31:26] == 6'h23) &&
           ((m_instr[20:16] == bus.id_instr[25:21]) ||
            (reads_rt && (m_instr[20:16] == bus.id_instr[20:16])));
  endfunction

  task automatic check_regs(input string tag);
    check_eq({tag, "_valid"}, 32'(bus.ex_valid), 32'(m_valid));
    check_eq({tag, "_op"}, 32'(bus.ex_op), 32'(m_instr[31:26]));
    check_eq({tag, "_funct"}, 32'(bus.ex_funct), 32'(m_instr[5:0]));
    check_eq({tag, "_rs"}, 32'(bus.ex_rs), 32'(m_instr[25:21]));
    check_eq({tag, "_rt"}, 32'(bus.ex_rt), 32'(m_instr[20:16]));
    check_eq({tag, "_rd"}, 32'(bus.ex_rd), 32'(m_instr[15:11]));
    check_eq({tag, "_imm"}, bus.ex_imm, 32'($signed(m_instr[15:0])));
    check_eq({tag, "_a"}, bus.ex_a, m_a);
    check_eq({tag, "_b"}, bus.ex_b, m_b);
    check_eq({tag, "_pc4"}, bus.ex_pc4, m_pc4);
    check_eq({tag, "_cnt"}, 32'(bus.bubble_cnt), 32'(m_cnt));
  endtask

  task automatic set_in(input logic v, input logic [31:0] instr, input logic [31:0] rd1,
                        input logic [31:0] rd2, input logic we, input logic [4:0] a3,
                        input logic [31:0] wd, input logic fl, input logic st);
    bus.id_valid = v;
    bus.id_instr = instr;
    bus.id_pc4   = $urandom;
    bus.rf_rd1   = rd1;
    bus.rf_rd2   = rd2;
    bus.wb_we    = we;
    bus.wb_a3    = a3;
    bus.wb_wd    = wd;
    bus.flush    = fl;
    bus.ex_stall = st;
  endtask

  // Called just after a falling edge with inputs applied; runs one clock of the model
  task automatic step(input string tag);
    logic        haz;
    logic [31:0] a;
    logic [31:0] b;
    #1;
    haz = model_haz();
    check_eq({tag, "_stall_id"}, 32'(bus.stall_id), 32'((haz || bus.ex_stall) && !bus.flush));
    check_eq({tag, "_rf_a1"}, 32'(bus.rf_a1), 32'(bus.id_instr[25:21]));
    check_eq({tag, "_rf_a2"}, 32'(bus.rf_a2), 32'(bus.id_instr[20:16]));
    a = (bus.wb_we && (bus.wb_a3 == bus.id_instr[25:21])) ? bus.wb_wd : bus.rf_rd1;
    b = (bus.wb_we && (bus.wb_a3 == bus.id_instr[20:16])) ? bus.wb_wd : bus.rf_rd2;
    @(posedge clk);
    if (bus.flush) begin
      model_clear_slot();
    end else if (bus.ex_stall) begin
      m_valid = m_valid;
    end else if (haz) begin
      model_clear_slot();
      if (m_cnt < CMAX) m_cnt++;
    end else begin
      m_valid = bus.id_valid;
      m_instr = bus.id_instr;
      m_a     = a;
      m_b     = b;
      m_pc4   = bus.id_pc4;
    end
    @(negedge clk);
    check_regs(tag);
  endtask

  task automatic reset_run(input string tag);
    rst = 1'b0;
    #1;
    model_clear_slot();
    m_cnt = 0;
    check_regs(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  localparam logic [31:0] I_ADD   = 32'h00221820;
  localparam logic [31:0] I_ADD_0 = 32'h00021820;
  localparam logic [31:0] I_LW    = 32'h8C090004;
  localparam logic [31:0] I_ADDU  = 32'h01215020;
  localparam logic [31:0] I_SW    = 32'hAC290000;
  localparam logic [31:0] I_ADDI  = 32'h20290005;

  initial begin
    logic [31:0] held_a;
    int          cnt_before;
    rst = 1'b0;
    set_in(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    model_clear_slot();
    m_cnt = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_regs("t1_reset");

    set_in(1'b1, I_ADD, 32'd5, 32'd7, 1'b0, 5'd1, 32'h0, 1'b0, 1'b0);
    step("t2");
    check_eq("t2_ex_a", bus.ex_a, 32'd5);
    check_eq("t2_ex_b", bus.ex_b, 32'd7);
    check_eq("t2_ex_rd", 32'(bus.ex_rd), 32'd3);
    check_eq("t2_ex_funct", 32'(bus.ex_funct), 32'h20);

    set_in(1'b1, I_ADD, 32'd5, 32'd7, 1'b1, 5'd1, 32'hDEAD, 1'b0, 1'b0);
    step("t3");
    check_eq("t3_ex_a", bus.ex_a, 32'hDEAD);
    check_eq("t3_ex_b", bus.ex_b, 32'd7);
    set_in(1'b1, I_ADD_0, 32'd5, 32'd7, 1'b1, 5'd0, 32'hDEAD, 1'b0, 1'b0);
    step("t3_r0");
    check_eq("t3_r0_ex_a", bus.ex_a, 32'hDEAD);

    set_in(1'b1, I_LW, 32'd0, 32'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    step("t4_lw");
    set_in(1'b1, I_ADDU, 32'h99, 32'h11, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1;
    check_eq("t4_stall_hi", 32'(bus.stall_id), 32'd1);
    step("t4_bubble");
    check_eq("t4_bubble_valid", 32'(bus.ex_valid), 32'd0);
    check_eq("t4_bubble_cnt", 32'(bus.bubble_cnt), 32'd1);
    step("t4_use");
    check_eq("t4_use_valid", 32'(bus.ex_valid), 32'd1);
    check_eq("t4_use_a", bus.ex_a, 32'h99);
    set_in(1'b1, I_LW, 32'd0, 32'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    step("t4_lw2");
    set_in(1'b1, I_SW, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1;
    check_eq("t4_sw_stall", 32'(bus.stall_id), 32'd1);
    step("t4_sw_bubble");
    step("t4_sw_use");
    set_in(1'b1, I_LW, 32'd0, 32'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    step("t4_lw3");
    set_in(1'b1, I_ADDI, 32'h3, 32'h4, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1;
    check_eq("t4_addi_nostall", 32'(bus.stall_id), 32'd0);
    step("t4_addi");

    set_in(1'b1, I_LW, 32'd0, 32'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    step("t5_lw");
    cnt_before = m_cnt;
    set_in(1'b1, I_ADDU, 32'h5, 32'h6, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
    #1;
    check_eq("t5_flush_stall_id", 32'(bus.stall_id), 32'd0);
    step("t5_flush");
    check_eq("t5_flush_valid", 32'(bus.ex_valid), 32'd0);
    check_eq("t5_flush_cnt", 32'(bus.bubble_cnt), 32'(cnt_before));
    set_in(1'b1, I_ADD, 32'h1234, 32'h5678, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    step("t5_load");
    held_a = m_a;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, {$urandom} & 32'h03FFFFFF, $urandom, $urandom, 1'b1, 5'd1, $urandom,
             1'b0, 1'b1);
      #1;
      check_eq("t5_frozen_stall_id", 32'(bus.stall_id), 32'd1);
      step("t5_frozen");
      check_eq("t5_frozen_a", bus.ex_a, held_a);
    end
    reset_run("t1_mid_reset");

    for (int i = 0; i < 300; i++) begin
      logic [5:0]  op;
      logic [31:0] instr;
      case ($urandom_range(0, 5))
        0:       op = 6'h00;
        1:       op = 6'h23;
        2:       op = 6'h23;
        3:       op = 6'h2B;
        4:       op = 6'h04;
        default: op = 6'h08;
      endcase
      instr = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
      set_in($urandom_range(0, 9) != 0, instr, $urandom, $urandom, 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), $urandom, $urandom_range(0, 9) == 0,
             $urandom_range(0, 4) == 0);
      step("rnd");
    end

    reset_run("t6_reset");
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, I_LW, 32'd0, 32'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      step("t6_lw");
      set_in(1'b1, I_ADDU, $urandom, $urandom, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      step("t6_bubble");
      step("t6_use");
    end
    check_eq("t6_saturated", 32'(bus.bubble_cnt), 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
